// File: rtl/pulse_meas.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pulse_meas                                                     |
// | Brief   : Measures high width (and optionally rise-to-rise period) of a  |
// |           clk-synchronous pulse. Optional: `PULSE_MEAS_PERIOD_EN.        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module pulse_meas #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             pulse_in,
   output logic [CNT_W-1:0] width_out,
   output logic             valid_out,
   output logic             overflow_out,
   output logic [15:0]      pulse_cnt_out,
   output logic [CNT_W-1:0] period_out,
   output logic             period_vld_out
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ARM       = 2'd1,
      S_WAIT_RISE = 2'd2,
      S_HIGH      = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] C_MAX = '1;
   localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_sat;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_sat         <= 1'b0;
         width_out     <= '0;
         valid_out     <= 1'b0;
         overflow_out  <= 1'b0;
         pulse_cnt_out <= '0;
      end else begin
         valid_out <= 1'b0;
         if (!en) begin
            // Abort: last width/overflow are kept, the pulse count restarts
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_sat         <= 1'b0;
            pulse_cnt_out <= '0;
         end else begin
            case (r_state)
               S_IDLE: r_state <= S_ARM;
               S_ARM: begin
                  if (!pulse_in) r_state <= S_WAIT_RISE;
               end
               S_WAIT_RISE: begin
                  if (pulse_in) begin
                     r_state <= S_HIGH;
                     r_cnt   <= C_ONE;
                     r_sat   <= 1'b0;
                  end
               end
               S_HIGH: begin
                  if (pulse_in) begin
                     if (r_cnt == C_MAX) r_sat <= 1'b1;
                     else                r_cnt <= r_cnt + C_ONE;
                  end else begin
                     r_state       <= S_WAIT_RISE;
                     valid_out     <= 1'b1;
                     width_out     <= r_cnt;
                     overflow_out  <= r_sat;
                     pulse_cnt_out <= pulse_cnt_out + 16'd1;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

`ifdef PULSE_MEAS_PERIOD_EN
   logic [CNT_W-1:0] r_pcnt;
   logic             r_have_rise;
   logic             w_rise;

   assign w_rise = en && (r_state == S_WAIT_RISE) && pulse_in;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pcnt         <= '0;
         r_have_rise    <= 1'b0;
         period_out     <= '0;
         period_vld_out <= 1'b0;
      end else begin
         period_vld_out <= 1'b0;
         if (!en || (r_state == S_IDLE) || (r_state == S_ARM)) begin
            r_pcnt      <= '0;
            r_have_rise <= 1'b0;
         end else if (w_rise) begin
            // Counter restarts at 1 so it reads the full rise-to-rise distance
            r_pcnt      <= C_ONE;
            r_have_rise <= 1'b1;
            if (r_have_rise) begin
               period_out     <= r_pcnt;
               period_vld_out <= 1'b1;
            end
         end else if (r_have_rise && (r_pcnt != C_MAX)) begin
            r_pcnt <= r_pcnt + C_ONE;
         end
      end
   end
`else
   assign period_out     = '0;
   assign period_vld_out = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pulse_meas.sv
`default_nettype none
// Directed self-checking bench for pulse_meas (CNT_W=32 and CNT_W=4 instances).
module tb_pulse_meas;
   logic        clk = 1'b0;
   logic        rst, en, pulse_in;
   logic [31:0] width_out, period_out;
   logic        valid_out, overflow_out, period_vld_out;
   logic [15:0] pulse_cnt_out;
   logic [3:0]  width4, period4;
   logic        valid4, ovf4, pvld4;
   logic [15:0] pcnt4;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   pulse_meas #(.CNT_W(32)) u_dut (
      .clk(clk), .rst(rst), .en(en), .pulse_in(pulse_in),
      .width_out(width_out), .valid_out(valid_out), .overflow_out(overflow_out),
      .pulse_cnt_out(pulse_cnt_out), .period_out(period_out),
      .period_vld_out(period_vld_out)
   );

   pulse_meas #(.CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .en(en), .pulse_in(pulse_in),
      .width_out(width4), .valid_out(valid4), .overflow_out(ovf4),
      .pulse_cnt_out(pcnt4), .period_out(period4), .period_vld_out(pvld4)
   );

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; en = 1'b0; pulse_in = 1'b0;
      tick(3);
      total++;
      if (width_out !== 32'd0 || valid_out !== 1'b0 || overflow_out !== 1'b0 ||
          pulse_cnt_out !== 16'd0 || period_out !== 32'd0 || period_vld_out !== 1'b0) begin
         bad++;
         $display("FAIL reset: width=%0d valid=%b ovf=%b pcnt=%0d period=%0d pvld=%b, required all 0",
                  width_out, valid_out, overflow_out, pulse_cnt_out, period_out, period_vld_out);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic;
      en = 1'b1;
      tick(2);
      pulse_in = 1'b1;
      tick(5);
      total++;
      if (valid_out !== 1'b0) begin
         bad++; $display("FAIL basic_early_valid: valid=%b required 0", valid_out);
      end
      pulse_in = 1'b0;
      tick();
      total++;
      if (valid_out !== 1'b1 || width_out !== 32'd5 || overflow_out !== 1'b0 || pulse_cnt_out !== 16'd1) begin
         bad++;
         $display("FAIL basic_report: valid=%b width=%0d ovf=%b pcnt=%0d required 1/5/0/1",
                  valid_out, width_out, overflow_out, pulse_cnt_out);
      end
      tick();
      total++;
      if (valid_out !== 1'b0 || width_out !== 32'd5) begin
         bad++; $display("FAIL basic_hold: valid=%b width=%0d required 0/5", valid_out, width_out);
      end
   endtask

   task automatic test_back_to_back;
      en = 1'b0;
      tick();
      total++;
      if (pulse_cnt_out !== 16'd0 || width_out !== 32'd5) begin
         bad++; $display("FAIL en_low_clear: pcnt=%0d width=%0d required 0/5", pulse_cnt_out, width_out);
      end
      en = 1'b1;
      tick(2);
      pulse_in = 1'b1; tick();
      pulse_in = 1'b0; tick();
      total++;
      if (valid_out !== 1'b1 || width_out !== 32'd1 || pulse_cnt_out !== 16'd1) begin
         bad++;
         $display("FAIL b2b_first: valid=%b width=%0d pcnt=%0d required 1/1/1", valid_out, width_out, pulse_cnt_out);
      end
      pulse_in = 1'b1; tick();
      total++;
      if (valid_out !== 1'b0) begin
         bad++; $display("FAIL b2b_strobe_len: valid=%b required 0", valid_out);
      end
      tick(2);
      pulse_in = 1'b0; tick();
      total++;
      if (valid_out !== 1'b1 || width_out !== 32'd3 || pulse_cnt_out !== 16'd2) begin
         bad++;
         $display("FAIL b2b_second: valid=%b width=%0d pcnt=%0d required 1/3/2", valid_out, width_out, pulse_cnt_out);
      end
   endtask

   task automatic test_already_high;
      logic seen;
      en = 1'b0; tick();
      pulse_in = 1'b1; en = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         if (valid_out) seen = 1'b1;
      end
      pulse_in = 1'b0; tick();
      if (valid_out) seen = 1'b1;
      total++;
      if (seen !== 1'b0) begin
         bad++; $display("FAIL armed_discard: strobe seen=%b required 0", seen);
      end
      pulse_in = 1'b1; tick(4);
      pulse_in = 1'b0; tick();
      total++;
      if (valid_out !== 1'b1 || width_out !== 32'd4 || pulse_cnt_out !== 16'd1) begin
         bad++;
         $display("FAIL after_discard: valid=%b width=%0d pcnt=%0d required 1/4/1", valid_out, width_out, pulse_cnt_out);
      end
   endtask

   task automatic test_abort;
      logic seen;
      seen = 1'b0;
      pulse_in = 1'b1; tick(2);
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (valid_out) seen = 1'b1;
         if (i == 3) pulse_in = 1'b0;
      end
      tick();
      if (valid_out) seen = 1'b1;
      total++;
      if (seen !== 1'b0 || pulse_cnt_out !== 16'd0 || width_out !== 32'd4) begin
         bad++;
         $display("FAIL abort: strobe=%b pcnt=%0d width=%0d required 0/0/4", seen, pulse_cnt_out, width_out);
      end
   endtask

   task automatic test_saturation;
      en = 1'b1; tick(2);
      pulse_in = 1'b1; tick(20);
      pulse_in = 1'b0; tick();
      total++;
      if (valid4 !== 1'b1 || width4 !== 4'd15 || ovf4 !== 1'b1) begin
         bad++; $display("FAIL sat_report: valid=%b width=%0d ovf=%b required 1/15/1", valid4, width4, ovf4);
      end
      total++;
      if (width_out !== 32'd20 || overflow_out !== 1'b0) begin
         bad++; $display("FAIL wide_no_sat: width=%0d ovf=%b required 20/0", width_out, overflow_out);
      end
      pulse_in = 1'b1; tick(2);
      pulse_in = 1'b0; tick();
      total++;
      if (valid4 !== 1'b1 || width4 !== 4'd2 || ovf4 !== 1'b0 || pcnt4 !== 16'd2) begin
         bad++;
         $display("FAIL sat_clear: valid=%b width=%0d ovf=%b pcnt=%0d required 1/2/0/2", valid4, width4, ovf4, pcnt4);
      end
   endtask

   task automatic test_period;
      en = 1'b0; tick();
      en = 1'b1; tick(2);
      for (int r = 0; r < 4; r++) begin
         pulse_in = 1'b1; tick();
`ifdef PULSE_MEAS_PERIOD_EN
         total++;
         if (r == 0) begin
            if (period_vld_out !== 1'b0) begin
               bad++; $display("FAIL period_first: pvld=%b required 0", period_vld_out);
            end
         end else if (period_vld_out !== 1'b1 || period_out !== 32'd10) begin
            bad++;
            $display("FAIL period_%0d: pvld=%b period=%0d required 1/10", r, period_vld_out, period_out);
         end
`else
         total++;
         if (period_vld_out !== 1'b0 || period_out !== 32'd0) begin
            bad++; $display("FAIL period_off_%0d: pvld=%b period=%0d required 0/0", r, period_vld_out, period_out);
         end
`endif
         tick(2);
         pulse_in = 1'b0; tick();
         total++;
         if (valid_out !== 1'b1 || width_out !== 32'd3) begin
            bad++; $display("FAIL period_width_%0d: valid=%b width=%0d required 1/3", r, valid_out, width_out);
         end
         tick();
         total++;
         if (period_vld_out !== 1'b0) begin
            bad++; $display("FAIL period_strobe_len_%0d: pvld=%b required 0", r, period_vld_out);
         end
         tick(5);
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; pulse_in = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_already_high();
      test_abort();
      test_saturation();
      test_period();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
